// File: rtl/fabric_config_pkg.sv
// Shared constants and parser state type for the fabric configuration bitstream path.
package fabric_config_pkg;

  localparam logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1;
  localparam logic [3:0]  OPC_FRAME_WR = 4'h1;
  localparam logic [3:0]  OPC_DESYNC   = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    CHECK,
    ERROR
  } parser_state_e;

endpackage

// File: rtl/fabric_frame_assembler.sv
// Frame assembly: shift buffer, word counter, output frame register and optional XOR checksum
// accumulator (FABRIC_CFG_CHECKSUM_EN).
module fabric_frame_assembler
  import fabric_config_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic                     commit_i,
  input  logic [31:0]              word_i,
  output logic                     last_o,
`ifdef FABRIC_CFG_CHECKSUM_EN
  output logic [31:0]              checksum_o,
`endif
  output logic [FRAME_WORDS*32-1:0] frame_o
);

  localparam int unsigned CW      = $clog2(FRAME_WORDS) + 1;
  localparam int unsigned FW_BITS = FRAME_WORDS * 32;

  logic [CW-1:0]      cnt_q;
  logic [FW_BITS-1:0] shift_q, shifted, shift_next, frame_q;

  if (FRAME_WORDS == 1) begin : g_single
    assign shifted = word_i;
  end else begin : g_multi
    assign shifted = {shift_q[FW_BITS-33:0], word_i};
  end

  always_comb begin
    shift_next = shift_q;
    if (load_i) shift_next = shifted;
  end

  // Output register takes the post-shift value so a commit coinciding with the final load
  // captures that last word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
      frame_q <= '0;
    end else begin
      if (clear_i)     cnt_q <= '0;
      else if (load_i) cnt_q <= cnt_q + CW'(1);
      shift_q <= shift_next;
      if (commit_i) frame_q <= shift_next;
    end
  end

`ifdef FABRIC_CFG_CHECKSUM_EN
  logic [31:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      acc_q <= '0;
    else if (clear_i) acc_q <= '0;
    else if (load_i)  acc_q <= acc_q ^ word_i;
  end

  assign checksum_o = acc_q;
`endif

  assign last_o  = (cnt_q == CW'(FRAME_WORDS - 1));
  assign frame_o = frame_q;

endmodule

// File: rtl/fabric_bitstream_parser.sv
// Bitstream parser: sync hunt, header decode, frame assembly and frame write strobe.
// Optional per-frame XOR checksum word enabled by FABRIC_CFG_CHECKSUM_EN.
module fabric_bitstream_parser
  import fabric_config_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned NUM_FRAMES  = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [31:0]               word_i,
  input  logic                      word_valid_i,
  output logic [FRAME_WORDS*32-1:0] frame_data_o,
  output logic [ADDR_WIDTH-1:0]     frame_addr_o,
  output logic                      frame_strobe_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  parser_state_e state_q, state_d;

  logic                  asm_clear, asm_load, commit, addr_load, done_set, err_set;
  logic                  last_word;
  logic                  strobe_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0] addr_q, frame_addr_q;
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic                  addr_ok;
  logic                  unused_hdr_bits;

  assign opcode          = word_i[31:28];
  assign hdr_addr        = word_i[ADDR_WIDTH-1:0];
  assign addr_ok         = 32'(hdr_addr) < NUM_FRAMES;
  assign unused_hdr_bits = ^word_i[27:ADDR_WIDTH];

`ifdef FABRIC_CFG_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  fabric_frame_assembler #(
    .FRAME_WORDS(FRAME_WORDS)
  ) u_assembler (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (asm_clear),
    .load_i     (asm_load),
    .commit_i   (commit),
    .word_i     (word_i),
    .last_o     (last_word),
`ifdef FABRIC_CFG_CHECKSUM_EN
    .checksum_o (checksum),
`endif
    .frame_o    (frame_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    asm_clear = 1'b0;
    asm_load  = 1'b0;
    commit    = 1'b0;
    addr_load = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    if (!enable_i) begin
      state_d   = IDLE;
      asm_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (word_valid_i && word_i == SYNC_WORD) state_d = HEADER;
        HEADER: begin
          if (word_valid_i && word_i != SYNC_WORD) begin
            if (opcode == OPC_FRAME_WR && addr_ok) begin
              addr_load = 1'b1;
              asm_clear = 1'b1;
              state_d   = DATA;
            end else if (opcode == OPC_DESYNC) begin
              done_set = 1'b1;
              state_d  = IDLE;
            end else begin
              err_set = 1'b1;
              state_d = ERROR;
            end
          end
        end
        DATA: begin
          if (word_valid_i) begin
            asm_load = 1'b1;
            if (last_word) begin
`ifdef FABRIC_CFG_CHECKSUM_EN
              state_d = CHECK;
`else
              commit  = 1'b1;
              state_d = HEADER;
`endif
            end
          end
        end
`ifdef FABRIC_CFG_CHECKSUM_EN
        CHECK: begin
          if (word_valid_i) begin
            if (word_i == checksum) begin
              commit  = 1'b1;
              state_d = HEADER;
            end else begin
              err_set = 1'b1;
              state_d = ERROR;
            end
          end
        end
`endif
        ERROR: state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      addr_q       <= '0;
      frame_addr_q <= '0;
    end else begin
      strobe_q <= commit;
      if (!enable_i) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        if (done_set) done_q  <= 1'b1;
        if (err_set)  error_q <= 1'b1;
      end
      if (addr_load) addr_q       <= hdr_addr;
      if (commit)    frame_addr_q <= addr_q;
    end
  end

  assign frame_addr_o   = frame_addr_q;
  assign frame_strobe_o = strobe_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_fabric_bitstream_parser.sv
// Self-checking bench for fabric_bitstream_parser: vector tables, directed sequences and
// randomized stream against a queue-based reference model (honours FABRIC_CFG_CHECKSUM_EN).
module tb_fabric_bitstream_parser;
  import fabric_config_pkg::*;

  localparam int unsigned FW = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned NF = 20;
  localparam int unsigned DW = FW * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   word = '0;
  logic [DW-1:0] frame_data;
  logic [AW-1:0] frame_addr;
  logic          frame_strobe, busy, done, error;

  always #5 clk = ~clk;

  fabric_bitstream_parser #(
    .FRAME_WORDS(FW),
    .ADDR_WIDTH (AW),
    .NUM_FRAMES (NF)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (en),
    .word_i        (word),
    .word_valid_i  (valid),
    .frame_data_o  (frame_data),
    .frame_addr_o  (frame_addr),
    .frame_strobe_o(frame_strobe),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_strobe = 0;

  // Reference model: protocol position expressed as flags plus a queue of collected words.
  bit            m_synced, m_err, m_done, m_in_frame, m_await;
  logic [31:0]   m_q[$];
  logic [AW-1:0] m_addr;
  bit            exp_strobe;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_addr;

  typedef struct {
    bit          en;
    bit          v;
    logic [31:0] w;
    bit          s;
    bit          b;
    bit          d;
    bit          e;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] q_xor();
    logic [31:0] x = '0;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  function automatic void emit();
    exp_strobe = 1'b1;
    exp_addr   = m_addr;
    for (int i = 0; i < int'(FW); i++) exp_data[(FW-1-i)*32 +: 32] = m_q[i];
    m_q.delete();
  endfunction

  function automatic void model_step(input bit e, input bit v, input logic [31:0] w);
    exp_strobe = 1'b0;
    if (!e) begin
      m_synced = 0; m_err = 0; m_done = 0; m_in_frame = 0; m_await = 0;
      m_q.delete();
    end else if (v && !m_err) begin
      if (!m_synced) begin
        m_synced = (w == SYNC_WORD);
      end else if (m_in_frame) begin
        m_q.push_back(w);
        if (m_q.size() == FW) begin
          m_in_frame = 0;
`ifdef FABRIC_CFG_CHECKSUM_EN
          m_await = 1;
`else
          emit();
`endif
        end
      end else if (m_await) begin
        m_await = 0;
        if (w == q_xor()) emit();
        else m_err = 1;
      end else if (w != SYNC_WORD) begin
        if (w[31:28] == 4'h1 && 32'(w[AW-1:0]) < NF) begin
          m_in_frame = 1;
          m_addr     = w[AW-1:0];
          m_q.delete();
        end else if (w[31:28] == 4'hF) begin
          m_done   = 1;
          m_synced = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit e, input bit v, input logic [31:0] w);
    en = e; valid = v; word = w;
    @(posedge clk);
    model_step(e, v, w);
    #1;
    if (frame_strobe) n_strobe++;
    chk("strobe", DW'(frame_strobe), DW'(exp_strobe));
    chk("busy",   DW'(busy),         DW'(m_synced || m_err));
    chk("done",   DW'(done),         DW'(m_done));
    chk("error",  DW'(error),        DW'(m_err));
    chk("data",   frame_data,        exp_data);
    chk("addr",   DW'(frame_addr),   DW'(exp_addr));
    @(negedge clk);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      en = tbl[i].en; valid = tbl[i].v; word = tbl[i].w;
      @(posedge clk);
      model_step(tbl[i].en, tbl[i].v, tbl[i].w);
      #1;
      if (frame_strobe) n_strobe++;
      chk($sformatf("tbl%0d_strobe", i), DW'(frame_strobe), DW'(tbl[i].s));
      chk($sformatf("tbl%0d_busy", i),   DW'(busy),         DW'(tbl[i].b));
      chk($sformatf("tbl%0d_done", i),   DW'(done),         DW'(tbl[i].d));
      chk($sformatf("tbl%0d_error", i),  DW'(error),        DW'(tbl[i].e));
      @(negedge clk);
    end
    tbl.delete();
  endtask

  task automatic send_frame(input logic [AW-1:0] a, input logic [31:0] base);
    logic [31:0] x = '0;
    step(1, 1, {4'h1, 20'h0, a});
    for (int i = 0; i < int'(FW); i++) begin
      step(1, 1, base + 32'(i));
      x ^= base + 32'(i);
    end
`ifdef FABRIC_CFG_CHECKSUM_EN
    step(1, 1, x);
`endif
  endtask

  initial begin
    int base_cnt;
    logic [31:0] rw;
    exp_data = '0; exp_addr = '0; exp_strobe = 0;
    m_synced = 0; m_err = 0; m_done = 0; m_in_frame = 0; m_await = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", DW'(frame_strobe), '0);
    chk("rst_busy",   DW'(busy),         '0);
    chk("rst_done",   DW'(done),         '0);
    chk("rst_error",  DW'(error),        '0);
    chk("rst_data",   frame_data,        '0);
    chk("rst_addr",   DW'(frame_addr),   '0);
    rst_n = 1'b1;

    // Single frame to address 3
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h1000_0003, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h1111_1111, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h2222_2222, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h3333_3333, 0, 1, 0, 0});
`ifdef FABRIC_CFG_CHECKSUM_EN
    tbl.push_back('{1, 1, 32'h4444_4444, 0, 1, 0, 0});
`endif
    tbl.push_back('{1, 1, 32'h4444_4444, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 32'h0,         0, 1, 0, 0});
    run_table();
    chk("t1_data", frame_data, 128'h11111111_22222222_33333333_44444444);
    chk("t1_addr", DW'(frame_addr), DW'(3));

    // Pre-sync garbage, unknown opcode, out-of-range and last-valid address, desync
    tbl.push_back('{0, 0, 32'h0,         0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'h1000_0001, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h7000_0000, 0, 1, 0, 1});
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 1});
    tbl.push_back('{1, 1, 32'h1000_0002, 0, 1, 0, 1});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 1, 32'h5555_0000 + 32'(i), 0, 1, 0, 1});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h1000_0014, 0, 1, 0, 1});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 1, 32'h6666_0000 + 32'(i), 0, 1, 0, 1});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 0, 0});
    tbl.push_back('{1, 1, 32'hFAB0_FAB1, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 32'h1000_0013, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 0, 0});
    run_table();

    // Two back-to-back frames then desync
    step(0, 0, 0);
    step(1, 1, SYNC_WORD);
    base_cnt = n_strobe;
    send_frame(8'd5, 32'hA000_0000);
    send_frame(8'd19, 32'hB000_0000);
    step(1, 1, 32'hF000_0000);
    step(1, 0, 0);
    chk("t5_strobes", DW'(n_strobe - base_cnt), DW'(2));
    chk("t5_data", frame_data, 128'hB0000000_B0000001_B0000002_B0000003);
    chk("t5_addr", DW'(frame_addr), DW'(19));
    chk("t5_done", DW'(done), DW'(1));
    chk("t5_busy", DW'(busy), DW'(0));

    // Enable dropped mid-frame discards the partial frame
    step(0, 0, 0);
    step(1, 1, SYNC_WORD);
    base_cnt = n_strobe;
    step(1, 1, 32'h1000_0002);
    step(1, 1, 32'hDDDD_0000);
    step(1, 1, 32'hDDDD_0001);
    step(0, 0, 0);
    step(1, 1, SYNC_WORD);
    send_frame(8'd4, 32'hC000_0000);
    step(1, 0, 0);
    chk("t6_strobes", DW'(n_strobe - base_cnt), DW'(1));
    chk("t6_addr", DW'(frame_addr), DW'(4));
    chk("t6_data", frame_data, 128'hC0000000_C0000001_C0000002_C0000003);

`ifdef FABRIC_CFG_CHECKSUM_EN
    // Bad checksum word
    step(0, 0, 0);
    step(1, 1, SYNC_WORD);
    base_cnt = n_strobe;
    step(1, 1, 32'h1000_0003);
    step(1, 1, 32'h1111_1111);
    step(1, 1, 32'h2222_2222);
    step(1, 1, 32'h3333_3333);
    step(1, 1, 32'h4444_4444);
    step(1, 1, 32'h0);
    step(1, 0, 0);
    chk("t7_strobes", DW'(n_strobe - base_cnt), DW'(0));
    chk("t7_error", DW'(error), DW'(1));
`endif

    // Randomized stream
    step(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 15))
        0, 1, 2: rw = SYNC_WORD;
        3, 4, 5, 6: rw = {4'h1, 20'($urandom), 8'($urandom_range(0, 23))};
        7: rw = {4'hF, 28'($urandom)};
        8: rw = {4'($urandom_range(2, 14)), 28'($urandom)};
        default: rw = $urandom;
      endcase
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
